// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, then shifts a byte, odd parity
// and stop bit out on device-generated clock falls, and checks the device ACK.
// Lines are open-drain: the OE outputs only ever pull low.
// Optional build macro PS2_HOST_TX_RETRY_EN: one silent retry of a failed
// transaction before oERR is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oDONE,
    output logic       oERR,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DAT_OE
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             fall;
    logic [8:0]       frame;     // {parity, data}
    logic [3:0]       nbit;      // clock falls seen in SEND
    logic [CNT_W-1:0] cnt;       // inhibit length, then cycles since clock release
    logic             in_xfer;
    logic             tmo_hit;
    logic             nack;
    logic             fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic             retried;
`endif

    // Two-flop synchronisers plus a delayed copy of the clock for fall detection.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], iPS2_CLK};
            dat_sync <= {dat_sync[0], iPS2_DAT};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign in_xfer = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    // Timeout is checked before the fall strobe so it wins a same-cycle tie.
    assign tmo_hit = in_xfer && (cnt == TMO_LAST);
    assign nack    = (state == ACK) && fall && dat_sync[1];
    assign fail    = tmo_hit || nack;

    // Transaction FSM with registered handshake and line-drive outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            oREADY      <= 1'b1;
            oDONE       <= 1'b0;
            oERR        <= 1'b0;
            oPS2_CLK_OE <= 1'b0;
            oPS2_DAT_OE <= 1'b0;
            frame       <= '0;
            nbit        <= '0;
            cnt         <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            oDONE <= 1'b0;
            oERR  <= 1'b0;
            if (fail) begin
                oPS2_CLK_OE <= 1'b0;
                oPS2_DAT_OE <= 1'b0;
                cnt         <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (!retried) begin
                    // First failure: replay the latched byte from the inhibit phase.
                    retried     <= 1'b1;
                    oPS2_CLK_OE <= 1'b1;
                    state       <= INHIBIT;
                end else begin
                    oERR   <= 1'b1;
                    oREADY <= 1'b1;
                    state  <= IDLE;
                end
`else
                oERR   <= 1'b1;
                oREADY <= 1'b1;
                state  <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (iVALID) begin
                            frame       <= {~^iDATA, iDATA};
                            cnt         <= '0;
                            oREADY      <= 1'b0;
                            oPS2_CLK_OE <= 1'b1;
                            oPS2_DAT_OE <= 1'b0;
                            state       <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                            retried     <= 1'b0;
`endif
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            oPS2_CLK_OE <= 1'b0;
                            oPS2_DAT_OE <= 1'b1;   // start bit
                            state       <= RTS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        // The RTS cycle itself is the first cycle after clock release.
                        cnt   <= CNT_W'(1);
                        nbit  <= '0;
                        state <= SEND;
                    end
                    SEND: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            if (nbit == 4'd9) begin
                                oPS2_DAT_OE <= 1'b0;   // stop bit
                                state       <= ACK;
                            end else begin
                                oPS2_DAT_OE <= ~frame[nbit];
                                nbit        <= nbit + 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        cnt <= cnt + 1'b1;
                        if (fall) state <= WAIT_IDLE;   // data was low: ACK
                    end
                    WAIT_IDLE: begin
                        cnt <= cnt + 1'b1;
                        if (clk_sync[1] && dat_sync[1]) begin
                            oDONE  <= 1'b1;
                            oREADY <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// on a wired-AND bus and a per-cycle protocol monitor.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 400;
    localparam int CW   = 12;
    localparam int HALF = 12;

    logic       iCLK   = 1'b0;
    logic       iRST   = 1'b1;
    logic [7:0] iDATA  = 8'h00;
    logic       iVALID = 1'b0;
    logic       oREADY, oDONE, oERR, oPS2_CLK_OE, oPS2_DAT_OE;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk, ps2_dat;

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    bit         exp_tmo  = 1'b0;
    logic [9:0] got_frame;

    assign ps2_clk = ~(oPS2_CLK_OE | dev_clk_low);
    assign ps2_dat = ~(oPS2_DAT_OE | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iVALID(iVALID),
        .oREADY(oREADY), .oDONE(oDONE), .oERR(oERR),
        .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
        .oPS2_CLK_OE(oPS2_CLK_OE), .oPS2_DAT_OE(oPS2_DAT_OE)
    );

    always #5 iCLK = ~iCLK;

    initial forever begin
        @(posedge iCLK);
        cyc++;
    end

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected line frame: data LSB first, odd parity, stop bit = 1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    // Per-cycle protocol monitor.
    initial begin
        bit prev_done = 1'b0;
        bit prev_err  = 1'b0;
        bit prev_cloe = 1'b0;
        int run       = 0;
        int rel_cyc   = 0;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                prev_done = 1'b0;
                prev_err  = 1'b0;
                prev_cloe = 1'b0;
                run       = 0;
            end else begin
                check_eq("done_err_excl", 32'(oDONE & oERR), 32'd0);
                if (oREADY) check_eq("idle_lines", 32'({oPS2_CLK_OE, oPS2_DAT_OE}), 32'd0);
                if (oDONE) begin
                    check_eq("done_ready", 32'(oREADY), 32'd1);
                    check_eq("done_width", 32'(prev_done), 32'd0);
                    done_cnt++;
                end
                if (oERR) begin
                    check_eq("err_ready", 32'(oREADY), 32'd1);
                    check_eq("err_width", 32'(prev_err), 32'd0);
                    if (exp_tmo) check_eq("timeout_len", 32'(cyc - rel_cyc), 32'(TMO));
                    err_cnt++;
                end
                if (oPS2_CLK_OE) begin
                    run++;
                end else if (prev_cloe) begin
                    check_eq("inhibit_len", 32'(run), 32'(INH));
                    run     = 0;
                    rel_cyc = cyc;
                end
                prev_done = oDONE;
                prev_err  = oERR;
                prev_cloe = oPS2_CLK_OE;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge iCLK);
        iDATA  = b;
        iVALID = 1'b1;
        @(negedge iCLK);
        iVALID = 1'b0;
        check_eq("accept", 32'(oREADY), 32'd0);
    endtask

    // Device: wait for RTS, clock up to stop_after falls, sample on rising edges.
    task automatic dev_xfer(input logic [7:0] b, input int stop_after, input bit ack, input bit chk);
        int t = 0;
        got_frame = '0;
        while (!(oPS2_CLK_OE == 1'b0 && oPS2_DAT_OE == 1'b1) && t < INH + 100) begin
            @(negedge iCLK);
            t++;
        end
        check_eq("rts_seen", 32'({oPS2_CLK_OE, oPS2_DAT_OE}), 32'd1);
        if (oPS2_DAT_OE !== 1'b1) return;
        repeat (HALF) @(negedge iCLK);
        for (int k = 1; k <= 11 && k <= stop_after; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge iCLK);
            dev_clk_low = 1'b0;
            if (k <= 10) got_frame[k-1] = ps2_dat;
            if (k == 10 && ack && stop_after >= 11) dev_dat_low = 1'b1;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (HALF) @(negedge iCLK);
        end
        if (chk && stop_after >= 10) check_eq("frame", 32'(got_frame), 32'(frame_of(b)));
    endtask

    task automatic wait_outcome(input string nm, input int bd, input int be,
                                input int exp_d, input int exp_e, input int budget);
        int t = 0;
        while (done_cnt == bd && err_cnt == be && t < budget) begin
            @(negedge iCLK);
            t++;
        end
        repeat (4) @(negedge iCLK);
        check_eq({nm, "_done"}, 32'(done_cnt - bd), 32'(exp_d));
        check_eq({nm, "_err"}, 32'(err_cnt - be), 32'(exp_e));
        check_eq({nm, "_ready"}, 32'(oREADY), 32'd1);
        check_eq({nm, "_lines"}, 32'({oPS2_CLK_OE, oPS2_DAT_OE}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int bd, be;
        repeat (3) @(negedge iCLK);
        check_eq("rst_ready", 32'(oREADY), 32'd1);
        check_eq("rst_pulses", 32'({oDONE, oERR}), 32'd0);
        check_eq("rst_lines", 32'({oPS2_CLK_OE, oPS2_DAT_OE}), 32'd0);
        iRST = 1'b0;
        repeat (3) @(negedge iCLK);

        // 0xED: data 1,0,1,1,0,1,1,1, parity 1, stop 1
        bd = done_cnt; be = err_cnt;
        send(8'hED);
        dev_xfer(8'hED, 11, 1'b1, 1'b1);
        check_eq("ed_line", 32'(got_frame), 32'h3ED);
        wait_outcome("ed", bd, be, 1, 0, 200);

        // 0x00 -> parity 1, 0x01 -> parity 0
        bd = done_cnt; be = err_cnt;
        send(8'h00);
        dev_xfer(8'h00, 11, 1'b1, 1'b1);
        check_eq("p00_line", 32'(got_frame), 32'h300);
        wait_outcome("p00", bd, be, 1, 0, 200);
        bd = done_cnt; be = err_cnt;
        send(8'h01);
        dev_xfer(8'h01, 11, 1'b1, 1'b1);
        check_eq("p01_line", 32'(got_frame), 32'h201);
        wait_outcome("p01", bd, be, 1, 0, 200);

        // NACK at edge 11
        bd = done_cnt; be = err_cnt;
        send(8'h55);
        dev_xfer(8'h55, 11, 1'b0, 1'b1);
`ifdef PS2_HOST_TX_RETRY_EN
        dev_xfer(8'h55, 11, 1'b1, 1'b1);
        wait_outcome("nack_retry", bd, be, 1, 0, 200);
`else
        wait_outcome("nack", bd, be, 0, 1, 200);
`endif

        // Device stops clocking after edge 4
        exp_tmo = 1'b1;
        bd = done_cnt; be = err_cnt;
        send(8'h12);
        dev_xfer(8'h12, 4, 1'b0, 1'b0);
        wait_outcome("timeout", bd, be, 0, 1, 3000);
        exp_tmo = 1'b0;

        // Reset while the device holds clock low at edge 6
        send(8'h77);
        dev_xfer(8'h77, 5, 1'b0, 1'b0);
        dev_clk_low = 1'b1;
        repeat (4) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check_eq("midrst_lines", 32'({oPS2_CLK_OE, oPS2_DAT_OE}), 32'd0);
        check_eq("midrst_ready", 32'(oREADY), 32'd1);
        check_eq("midrst_pulses", 32'({oDONE, oERR}), 32'd0);
        bd = done_cnt; be = err_cnt;
        @(negedge iCLK);
        iRST = 1'b0;
        dev_clk_low = 1'b0;
        repeat (60) @(negedge iCLK);
        check_eq("postrst_done", 32'(done_cnt - bd), 32'd0);
        check_eq("postrst_err", 32'(err_cnt - be), 32'd0);
        check_eq("postrst_ready", 32'(oREADY), 32'd1);

        bd = done_cnt; be = err_cnt;
        send(8'hF4);
        dev_xfer(8'hF4, 11, 1'b1, 1'b1);
        wait_outcome("f4", bd, be, 1, 0, 200);

        // iVALID held high while iDATA changes mid-transfer
        bd = done_cnt; be = err_cnt;
        @(negedge iCLK);
        iDATA  = 8'hA5;
        iVALID = 1'b1;
        @(negedge iCLK);
        check_eq("hold_accept", 32'(oREADY), 32'd0);
        iDATA = 8'h3C;
        dev_xfer(8'hA5, 11, 1'b1, 1'b1);
        check_eq("hold_first_done", 32'(done_cnt - bd), 32'd1);
        check_eq("hold_second_accepted", 32'(oREADY), 32'd0);
        iVALID = 1'b0;
        dev_xfer(8'h3C, 11, 1'b1, 1'b1);
        wait_outcome("hold_second", bd + 1, be, 1, 0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
